// File: rtl/arb_requester.sv
// Requester-side agent for a 4-way round-robin arbiter: turns burst commands into
// per-channel requests, consumes one beat per grant and checks the grant vectors it sees.
module arb_requester #(
    parameter int N     = 4,
    parameter int LEN_W = 4,
    parameter int CNT_W = 16,
    localparam int CH_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CH_W-1:0]  cmd_ch,
    input  logic [LEN_W-1:0] cmd_len,
    output logic [N-1:0]     req,
    input  logic [N-1:0]     grant,
    output logic             beat_valid,
    output logic [CH_W-1:0]  beat_ch,
    output logic [N-1:0]     done,
    output logic [CNT_W-1:0] beat_cnt,
    output logic [CNT_W-1:0] waste_cnt,
    output logic             grant_err
);

    localparam logic [LEN_W:0] REM_ONE = (LEN_W+1)'(1);
    localparam logic [N-1:0]   N_ONE   = N'(1);

    logic [LEN_W:0]   rem_q [N];
    logic [LEN_W:0]   rem_d [N];
    logic             beat_valid_q, beat_valid_d;
    logic [CH_W-1:0]  beat_ch_q, beat_ch_d;
    logic [N-1:0]     done_q, done_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0] waste_cnt_q, waste_cnt_d;
    logic             grant_err_q, grant_err_d;

    logic [N-1:0] req_w;
    logic [N-1:0] consume;
    logic         multi_grant;
    logic         stale;
    logic         accept;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_w[i] = (rem_q[i] != '0);
        end
    end

    assign req       = req_w;
    assign cmd_ready = (rem_q[cmd_ch] == '0);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        multi_grant  = ((grant & (grant - N_ONE)) != '0);
        // A malformed grant vector consumes nothing and is not counted as waste.
        consume      = multi_grant ? '0 : (grant & req_w);
        stale        = !multi_grant && ((grant & ~req_w) != '0);
        accept       = cmd_valid && cmd_ready;
        beat_valid_d = |consume;
        beat_ch_d    = beat_ch_q;
        done_d       = '0;
        for (int i = 0; i < N; i++) begin
            rem_d[i] = rem_q[i];
            if (consume[i]) begin
                rem_d[i]  = rem_q[i] - REM_ONE;
                beat_ch_d = CH_W'(i);
                done_d[i] = (rem_q[i] == REM_ONE);
            end else if (accept && (cmd_ch == CH_W'(i))) begin
                rem_d[i] = {1'b0, cmd_len} + REM_ONE;
            end
        end
        beat_cnt_d  = beat_cnt_q + CNT_W'(beat_valid_d);
        waste_cnt_d = (stale && (waste_cnt_q != '1)) ? waste_cnt_q + CNT_W'(1) : waste_cnt_q;
        grant_err_d = grant_err_q | multi_grant;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    // NOTE: the remaining-count array is a handful of flops, not a RAM, so it is reset with everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                rem_q[i] <= '0;
            end
            beat_valid_q <= 1'b0;
            beat_ch_q    <= '0;
            done_q       <= '0;
            beat_cnt_q   <= '0;
            waste_cnt_q  <= '0;
            grant_err_q  <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                rem_q[i] <= rem_d[i];
            end
            beat_valid_q <= beat_valid_d;
            beat_ch_q    <= beat_ch_d;
            done_q       <= done_d;
            beat_cnt_q   <= beat_cnt_d;
            waste_cnt_q  <= waste_cnt_d;
            grant_err_q  <= grant_err_d;
        end
    end

    assign beat_valid = beat_valid_q;
    assign beat_ch    = beat_ch_q;
    assign done       = done_q;
    assign beat_cnt   = beat_cnt_q;
    assign waste_cnt  = waste_cnt_q;
    assign grant_err  = grant_err_q;

endmodule

// File: tb/tb_arb_requester.sv
// Bench for arb_requester: a registered round-robin arbiter model drives grant, and a
// reference model plus beat scoreboard predicts every output cycle by cycle.
module tb_arb_requester;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_ch;
    logic [3:0]  cmd_len;
    logic [3:0]  req;
    logic [3:0]  grant;
    logic        beat_valid;
    logic [1:0]  beat_ch;
    logic [3:0]  done;
    logic [15:0] beat_cnt;
    logic [15:0] waste_cnt;
    logic        grant_err;

    arb_requester #(.N(4), .LEN_W(4), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_ch     (cmd_ch),
        .cmd_len    (cmd_len),
        .req        (req),
        .grant      (grant),
        .beat_valid (beat_valid),
        .beat_ch    (beat_ch),
        .done       (done),
        .beat_cnt   (beat_cnt),
        .waste_cnt  (waste_cnt),
        .grant_err  (grant_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [1:0] ch;
        logic       last;
    } beat_t;

    typedef struct {
        logic        cv;
        logic [1:0]  ch;
        logic [3:0]  len;
        logic [3:0]  g;
        logic        bv;
        logic [15:0] waste;
        logic        err;
        logic [15:0] bc;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          m_rem [4];
    logic [15:0] m_beat;
    logic [15:0] m_waste;
    logic        m_err;
    beat_t       sb [$];
    logic [3:0]  arb_q;
    int          arb_ptr;
    int          done_seen [4];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_req();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (m_rem[i] != 0);
        return r;
    endfunction

    function automatic logic model_busy();
        return model_req() != 4'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_rem[i] = 0;
        m_beat  = '0;
        m_waste = '0;
        m_err   = 1'b0;
        sb.delete();
        arb_q   = '0;
        arb_ptr = 3;
    endtask

    // One clock cycle: drive at negedge, check request side, update models at posedge, check outputs.
    task automatic step(input logic cv, input logic [1:0] ch, input logic [3:0] len,
                        input logic use_arb, input logic [3:0] g, output logic acc);
        logic [3:0] gd;
        logic [3:0] mreq;
        logic [3:0] nxt;
        beat_t      b;
        @(negedge clk);
        gd        = use_arb ? arb_q : g;
        cmd_valid = cv;
        cmd_ch    = ch;
        cmd_len   = len;
        grant     = gd;
        mreq      = model_req();
        #1;
        check("req", req, mreq);
        check("cmd_ready", cmd_ready, m_rem[ch] == 0);
        @(posedge clk);
        nxt = '0;
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (arb_ptr + k) % 4;
            if (nxt == 4'b0 && mreq[idx]) begin
                nxt[idx] = 1'b1;
                arb_ptr  = idx;
            end
        end
        arb_q = nxt;
        acc = cv && (m_rem[ch] == 0);
        if ($countones(gd) > 1) begin
            m_err = 1'b1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (gd[i]) begin
                    if (m_rem[i] != 0) begin
                        b.ch   = 2'(i);
                        b.last = (m_rem[i] == 1);
                        sb.push_back(b);
                        m_rem[i]--;
                        m_beat++;
                    end else if (m_waste != 16'hffff) begin
                        m_waste++;
                    end
                end
            end
        end
        if (acc) m_rem[ch] = int'(len) + 1;
        #1;
        if (sb.size() > 0) begin
            b = sb.pop_front();
            check("beat_valid", beat_valid, 1'b1);
            check("beat_ch", beat_ch, b.ch);
            check("done", done, b.last ? (4'b0001 << b.ch) : 4'b0000);
        end else begin
            check("beat_valid_idle", beat_valid, 1'b0);
            check("done_idle", done, 4'b0000);
        end
        for (int i = 0; i < 4; i++) if (done[i] === 1'b1) done_seen[i]++;
        check("beat_cnt", beat_cnt, m_beat);
        check("waste_cnt", waste_cnt, m_waste);
        check("grant_err", grant_err, m_err);
    endtask

    task automatic send(input logic [1:0] ch, input logic [3:0] len);
        logic acc;
        acc = 1'b0;
        for (int k = 0; k < 200 && !acc; k++) step(1'b1, ch, len, 1'b1, 4'b0, acc);
        check("send_accepted", acc, 1'b1);
    endtask

    task automatic drain();
        logic acc;
        for (int k = 0; k < 300 && model_busy(); k++) step(1'b0, 2'd0, 4'd0, 1'b1, 4'b0, acc);
        check("drain_timeout", model_busy(), 1'b0);
        step(1'b0, 2'd0, 4'd0, 1'b1, 4'b0, acc);
        step(1'b0, 2'd0, 4'd0, 1'b1, 4'b0, acc);
    endtask

    task automatic apply_reset(input logic check_now);
        @(negedge clk);
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        grant     = 4'b0;
        #1;
        if (check_now) begin
            check("rst_req", req, 4'b0);
            check("rst_beat_cnt", beat_cnt, 16'd0);
            check("rst_waste_cnt", waste_cnt, 16'd0);
            check("rst_grant_err", grant_err, 1'b0);
            check("rst_done", done, 4'b0);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t tbl [10];

    initial begin
        logic acc;
        tbl[0] = '{1'b0, 2'd0, 4'd0, 4'b0010, 1'b0, 16'd1, 1'b0, 16'd0};
        tbl[1] = '{1'b0, 2'd0, 4'd0, 4'b0000, 1'b0, 16'd1, 1'b0, 16'd0};
        tbl[2] = '{1'b1, 2'd1, 4'd0, 4'b0000, 1'b0, 16'd1, 1'b0, 16'd0};
        tbl[3] = '{1'b0, 2'd0, 4'd0, 4'b0010, 1'b1, 16'd1, 1'b0, 16'd1};
        tbl[4] = '{1'b0, 2'd0, 4'd0, 4'b0010, 1'b0, 16'd2, 1'b0, 16'd1};
        tbl[5] = '{1'b1, 2'd2, 4'd1, 4'b0011, 1'b0, 16'd2, 1'b1, 16'd1};
        tbl[6] = '{1'b0, 2'd0, 4'd0, 4'b0100, 1'b1, 16'd2, 1'b1, 16'd2};
        tbl[7] = '{1'b0, 2'd0, 4'd0, 4'b0110, 1'b0, 16'd2, 1'b1, 16'd2};
        tbl[8] = '{1'b0, 2'd0, 4'd0, 4'b0100, 1'b1, 16'd2, 1'b1, 16'd3};
        tbl[9] = '{1'b0, 2'd0, 4'd0, 4'b0000, 1'b0, 16'd2, 1'b1, 16'd3};

        for (int i = 0; i < 4; i++) done_seen[i] = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_ch    = 2'd0;
        cmd_len   = 4'd0;
        grant     = 4'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset
        #1;
        check("init_req", req, 4'b0);
        check("init_cmd_ready", cmd_ready, 1'b1);
        check("init_beat_cnt", beat_cnt, 16'd0);
        check("init_waste_cnt", waste_cnt, 16'd0);
        check("init_grant_err", grant_err, 1'b0);
        step(1'b0, 2'd0, 4'd0, 1'b1, 4'b0, acc);

        // Single three-beat burst on channel 2
        send(2'd2, 4'd2);
        drain();
        check("t2_beat_cnt", beat_cnt, 16'd3);
        check("t2_done2", done_seen[2], 1);

        // Three back-to-back bursts, then a second command to busy channel 1
        send(2'd0, 4'd3);
        send(2'd1, 4'd3);
        send(2'd3, 4'd3);
        send(2'd1, 4'd1);
        drain();
        check("t3_beat_cnt", beat_cnt, 16'd17);
        check("t3_grant_err", grant_err, 1'b0);
        check("t3_done0", done_seen[0], 1);
        check("t3_done1", done_seen[1], 2);
        check("t3_done3", done_seen[3], 1);

        // Directed grant vectors from a clean reset
        apply_reset(1'b0);
        for (int r = 0; r < 10; r++) begin
            step(tbl[r].cv, tbl[r].ch, tbl[r].len, 1'b0, tbl[r].g, acc);
            check($sformatf("tbl%0d_bv", r), beat_valid, tbl[r].bv);
            check($sformatf("tbl%0d_waste", r), waste_cnt, tbl[r].waste);
            check($sformatf("tbl%0d_err", r), grant_err, tbl[r].err);
            check($sformatf("tbl%0d_bc", r), beat_cnt, tbl[r].bc);
        end

        // Reset in the middle of a five-beat burst on channel 0
        step(1'b1, 2'd0, 4'd4, 1'b0, 4'b0, acc);
        step(1'b0, 2'd0, 4'd0, 1'b0, 4'b0, acc);
        check("mid_req_before", req, 4'b0001);
        for (int i = 0; i < 4; i++) done_seen[i] = 0;
        apply_reset(1'b1);
        step(1'b0, 2'd0, 4'd0, 1'b0, 4'b0, acc);
        check("mid_no_done", done_seen[0], 0);
        send(2'd0, 4'd1);
        drain();
        check("mid_beat_cnt", beat_cnt, 16'd2);
        check("mid_done0", done_seen[0], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arb_requester.md
Name: arb_requester

Overview:
- Requester-side agent for the 4-way round-robin arbiter (arbiter_rr).
- Accepts burst commands (channel, length) from a command port.
- For each channel it drives req high until that channel has received one grant per beat, then reports each consumed beat and a per-channel completion pulse.
- Also counts wasted grants and flags malformed grant vectors, so it serves as the client front end and as a checker of the arbiter.

Parameters:
- N, 4, number of requesting channels; width of req/grant.
- LEN_W, 4, width of the burst-length field; a burst is cmd_len+1 beats (1..2^LEN_W).
- CNT_W, 16, width of the beat and wasted-grant counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command accepted this cycle when high with cmd_valid.
- cmd_ch  input  $clog2(N)  target channel of the command.
- cmd_len  input  LEN_W  burst length minus one.
- req  output  N  request vector to the arbiter.
- grant  input  N  grant vector from the arbiter (expected one-hot or zero).
- beat_valid  output  1  one beat consumed last cycle.
- beat_ch  output  $clog2(N)  channel of that beat.
- done  output  N  one-cycle pulse per channel when its final beat is consumed.
- beat_cnt  output  CNT_W  total beats consumed since reset.
- waste_cnt  output  CNT_W  grants received on channels with req low.
- grant_err  output  1  sticky error flag.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all remaining[i]=0, req=0, beat_valid=0, beat_ch=0, done=0, beat_cnt=0, waste_cnt=0, grant_err=0. cmd_ready is high after reset.
- Per-channel state: remaining[i], LEN_W+1 bits. Channel state is IDLE when remaining[i]==0, otherwise ACTIVE. req[i] = (remaining[i]!=0), driven directly from the register with no combinational path from grant.
- cmd_ready is combinational and equals (remaining[cmd_ch]==0).
- Accept: on a rising edge with cmd_valid && cmd_ready, remaining[cmd_ch] <= cmd_len+1. req[cmd_ch] rises in the following cycle.
- Commands to a busy channel stall (cmd_ready=0). Commands to other channels are unaffected, so there is no head-of-line blocking across channels.
- Beat consume: on an edge where grant[i] && req[i], remaining[i] decrements by 1.
  - Next cycle: beat_valid=1, beat_ch=i, and beat_cnt increments (wraps at 2^CNT_W).
  - If remaining[i] was 1: done[i] pulses for exactly one cycle in that same next cycle, and req[i] is low from that next cycle.
- Stale grants: grant[i] high while req[i] low is legal, because the arbiter is registered and lags req by one cycle. Such a grant is ignored, waste_cnt increments (saturating at all-ones), and grant_err is not set.
- Grant errors: grant with more than one bit set sets grant_err, which stays high until reset.
  - No beat is consumed that cycle on any channel.
  - waste_cnt is unchanged.
- Reload timing: a channel cannot reload on its own last-beat edge, because cmd_ready is still low. The earliest reload is the cycle after the last beat. This yields at least one req-low cycle between bursts on a channel, which lets the arbiter rotate.
- Simultaneous accept and consume: an accept for channel j and a consume for channel k!=j on the same edge are both applied.
- Reset mid-burst: remaining, req and the counters clear immediately and asynchronously. No done pulse is issued for the aborted burst.
- Outputs beat_valid, beat_ch, done, beat_cnt, waste_cnt and grant_err are registered.

Test Plan:
- Reset release, no commands, grant=0 -> req=0, cmd_ready=1, beat_cnt=0, waste_cnt=0, grant_err=0.
- cmd ch=2 len=2, with arbiter_rr connected -> req=4'b0100 for 3 grant cycles; beat_valid asserts 3 times with beat_ch=2; done[2] pulses once on the third beat; beat_cnt=3; req[2] falls in the same cycle as the done pulse.
- Commands ch0 len=3, ch1 len=3, ch3 len=3 back-to-back, with arbiter_rr -> beats interleave in round-robin order; each of done[0], done[1], done[3] pulses once; beat_cnt=12; grant_err=0.
- Second cmd to ch1 while ch1 is active -> cmd_ready=0 until the cycle after done[1]; the cmd then completes with the correct beat count.
- Force grant=4'b0010 while req=0 -> waste_cnt=1, no beat, grant_err=0. Then force grant=4'b0011 -> grant_err=1 and stays 1; beat_cnt unchanged.
- Assert rst_n=0 mid-burst (ch0 with remaining=5) -> req=0 and beat_cnt=0 immediately; no done pulse; after release, a new cmd on ch0 is accepted normally.
